load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, data word width.
REQ-002 SHALL have parameter MEMORY_SIZE, default 32, byte-address width and memory word-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, request present from execute.
REQ-006 SHALL have port req_ready, output, 1, request accepted this cycle when it and req_valid are both high.
REQ-007 SHALL have port req_is_load, input, 1, and port req_is_store, input, 1, giving the operation class.
REQ-008 SHALL have port req_funct3, input, 3, giving the RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port req_addr, input, MEMORY_SIZE, the byte address.
REQ-010 SHALL have port req_wdata, input, WORD_LENGTH, the store data (low bytes used for B/H).
REQ-011 SHALL have port rsp_valid, output, 1, a single-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, WORD_LENGTH, the extended load result.
REQ-013 SHALL have port rsp_misaligned, output, 1, and port rsp_illegal, output, 1, as completion error flags.
REQ-014 SHALL have memory-side outputs mem_address (MEMORY_SIZE), mem_write_add (MEMORY_SIZE), mem_write_data (WORD_LENGTH), mem_write_enable (1), mem_read_enable (1), and input mem_data_out (WORD_LENGTH), with combinational read data.

Function
REQ-015 SHALL implement FSM states IDLE, MERGE and RESP; req_ready SHALL be high only in IDLE.
REQ-016 SHALL drive mem_address and mem_write_add with the word address, i.e. req_addr shifted right by 2 (registered copy in MERGE).
REQ-017 SHALL, on acceptance of a legal load, assert mem_read_enable in that cycle, register the byte/half/word selected by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU), then go to RESP; load latency is 1 cycle.
REQ-018 SHALL, on acceptance of a legal SW, assert mem_write_enable with req_wdata in that cycle, then go to RESP; rsp_rdata SHALL be 0.
REQ-019 SHALL, on acceptance of a legal SB/SH, read the word in the accept cycle, register it, and go to MERGE.
REQ-020 SHALL, in MERGE, write the word with only the addressed byte/halfword replaced and all other bytes unchanged, then go to RESP; sub-word store latency is 2 cycles.
REQ-021 SHALL, in RESP, pulse rsp_valid for exactly one cycle and then return to IDLE; there is no response backpressure.
REQ-022 SHALL flag as misaligned: H/HU/SH with addr[0]=1, and W/SW with addr[1:0]!=00; such a request SHALL make no memory access and SHALL respond with rsp_misaligned=1 and rsp_rdata=0.
REQ-023 SHALL flag as illegal: funct3 011/110/111, stores with funct3 100/101, both class bits high, or both class bits low; such a request SHALL make no memory access and SHALL respond with rsp_illegal=1. Illegal SHALL take priority over misaligned.
REQ-024 SHALL hold mem_write_enable and mem_read_enable low whenever no legal access is in progress.
REQ-025 SHALL ignore request inputs outside IDLE.

Reset
REQ-026 SHALL, on rst high at a clock edge, enter IDLE, clear rsp_valid, rsp_rdata, rsp_misaligned, rsp_illegal and all internal registers.
REQ-027 SHALL force mem_write_enable low while rst is high; a reset during MERGE SHALL abort the store with no memory write.

Structure
REQ-028 SHALL place the funct3 encodings and the FSM state encoding in shared package lsu_pkg.
REQ-029 SHALL place load extraction/extension and store byte-merge in one combinational sub-module, lsu_align.

Verification
REQ-030 SHALL cover: memory word 0x8000_00F0 at addr 0x10; LB 0x10 -> rsp_rdata 0xFFFF_FFF0 one cycle later; LBU 0x13 -> 0x0000_0080; LH 0x12 -> 0xFFFF_8000.
REQ-031 SHALL cover: word 0x1122_3344 at 0x20; SB 0x21 with data 0xAB -> one write of 0x1122_AB44 in MERGE, rsp_valid 2 cycles after acceptance.
REQ-032 SHALL cover: SW 0x24 with data 0xDEAD_BEEF -> write in the accept cycle, rsp_valid next cycle, LW 0x24 returns 0xDEAD_BEEF.
REQ-033 SHALL cover: LW 0x22 and SH 0x23 -> rsp_misaligned=1, no mem enable asserted; funct3 011 load -> rsp_illegal=1.
REQ-034 SHALL cover: SH 0x20 accepted, rst high in the MERGE cycle -> no write, memory still 0x1122_3344, FSM in IDLE, req_ready high.
REQ-035 SHALL cover: req_valid held high continuously -> req_ready low in MERGE/RESP and exactly one acceptance per completion.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and request classification for the load/store unit.
package lsu_pkg;

  // RV32I width/sign codes carried in funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MERGE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // Unknown width codes, unsigned stores and ambiguous class bits are illegal.
  function automatic logic is_illegal(input logic is_load, input logic is_store,
                                      input logic [2:0] funct3);
    logic bad_code;
    bad_code = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    return (is_load == is_store) || bad_code ||
           (is_store && (funct3 == F3_BU || funct3 == F3_HU));
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (funct3 == F3_H || funct3 == F3_HU) mis = offset[0];
    else if (funct3 == F3_W)               mis = (offset != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction/extension and store read-modify-write merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic [2:0]             funct3,
  input  logic [1:0]             offset,
  input  logic [WORD_LENGTH-1:0] rd_word,
  input  logic [WORD_LENGTH-1:0] wr_data,
  output logic [WORD_LENGTH-1:0] load_data,
  output logic [WORD_LENGTH-1:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, extend it for loads and splice it in for stores.
  always_comb begin
    byte_sel    = rd_word[{offset, 3'b000} +: 8];
    half_sel    = rd_word[{offset[1], 4'b0000} +: 16];
    load_data   = '0;
    merged_word = rd_word;
    case (funct3)
      F3_B: begin
        load_data = {{(WORD_LENGTH-8){byte_sel[7]}}, byte_sel};
        merged_word[{offset, 3'b000} +: 8] = wr_data[7:0];
      end
      F3_H: begin
        load_data = {{(WORD_LENGTH-16){half_sel[15]}}, half_sel};
        merged_word[{offset[1], 4'b0000} +: 16] = wr_data[15:0];
      end
      F3_W: begin
        load_data   = rd_word;
        merged_word = wr_data;
      end
      F3_BU:   load_data = {{(WORD_LENGTH-8){1'b0}}, byte_sel};
      F3_HU:   load_data = {{(WORD_LENGTH-16){1'b0}}, half_sel};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time; loads and word stores finish in one
// cycle, byte/half stores do a read in the accept cycle and a merged write in MERGE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int MEMORY_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_load,
  input  logic                   req_is_store,
  input  logic [2:0]             req_funct3,
  input  logic [MEMORY_SIZE-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [WORD_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_misaligned,
  output logic                   rsp_illegal,
  output logic [MEMORY_SIZE-1:0] mem_address,
  output logic [MEMORY_SIZE-1:0] mem_write_add,
  output logic [WORD_LENGTH-1:0] mem_write_data,
  output logic                   mem_write_enable,
  output logic                   mem_read_enable,
  input  logic [WORD_LENGTH-1:0] mem_data_out
);

  state_e                 state_q, state_d;
  logic [MEMORY_SIZE-1:0] addr_q, addr_d;
  logic [1:0]             offset_q, offset_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic [WORD_LENGTH-1:0] word_q, word_d;
  logic [WORD_LENGTH-1:0] rdata_q, rdata_d;
  logic                   misaligned_q, misaligned_d;
  logic                   illegal_q, illegal_d;

  logic [MEMORY_SIZE-1:0] req_word_addr;
  logic                   acc_illegal, acc_misaligned;
  logic                   read_req, write_req;
  logic [2:0]             align_funct3;
  logic [1:0]             align_offset;
  logic [WORD_LENGTH-1:0] align_word, align_wdata, load_data, merged_word;

  assign req_word_addr  = req_addr >> 2;
  assign acc_illegal    = is_illegal(req_is_load, req_is_store, req_funct3);
  assign acc_misaligned = !acc_illegal && is_misaligned(req_funct3, req_addr[1:0]);

  lsu_align #(.WORD_LENGTH(WORD_LENGTH)) u_align (
    .funct3      (align_funct3),
    .offset      (align_offset),
    .rd_word     (align_word),
    .wr_data     (align_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Next-state, memory strobes and response capture.
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves one unassigned (no latches).
    state_d        = state_q;
    addr_d         = addr_q;
    offset_d       = offset_q;
    funct3_d       = funct3_q;
    wdata_d        = wdata_q;
    word_d         = word_q;
    rdata_d        = rdata_q;
    misaligned_d   = misaligned_q;
    illegal_d      = illegal_q;
    req_ready      = (state_q == S_IDLE);
    read_req       = 1'b0;
    write_req      = 1'b0;
    mem_address    = req_word_addr;
    mem_write_add  = req_word_addr;
    mem_write_data = req_wdata;
    align_funct3   = req_funct3;
    align_offset   = req_addr[1:0];
    align_word     = mem_data_out;
    align_wdata    = req_wdata;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          illegal_d    = acc_illegal;
          misaligned_d = acc_misaligned;
          rdata_d      = '0;
          state_d      = S_RESP;
          if (!acc_illegal && !acc_misaligned) begin
            if (req_is_load) begin
              read_req = 1'b1;
              rdata_d  = load_data;
            end else if (req_funct3 == F3_W) begin
              write_req = 1'b1;
            end else begin
              read_req = 1'b1;
              word_d   = mem_data_out;
              addr_d   = req_word_addr;
              offset_d = req_addr[1:0];
              funct3_d = req_funct3;
              wdata_d  = req_wdata;
              state_d  = S_MERGE;
            end
          end
        end
      end
      S_MERGE: begin
        align_funct3   = funct3_q;
        align_offset   = offset_q;
        align_word     = word_q;
        align_wdata    = wdata_q;
        mem_address    = addr_q;
        mem_write_add  = addr_q;
        mem_write_data = merged_word;
        write_req      = 1'b1;
        state_d        = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A reset in MERGE must never let the pending merged write reach memory.
  assign mem_write_enable = write_req & ~rst;
  assign mem_read_enable  = read_req & ~rst;

  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = misaligned_q;
  assign rsp_illegal    = illegal_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      offset_q     <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      offset_q     <= offset_d;
      funct3_q     <= funct3_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: small word memory, cycle-level reference model,
// directed cases with literal expectations and a randomized request stream.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_misaligned, rsp_illegal;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_write_add, mem_write_data, mem_data_out;
  logic        mem_write_enable, mem_read_enable;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_LENGTH(32), .MEMORY_SIZE(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_is_load      (req_is_load),
    .req_is_store     (req_is_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_misaligned   (rsp_misaligned),
    .rsp_illegal      (rsp_illegal),
    .mem_address      (mem_address),
    .mem_write_add    (mem_write_add),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_data_out     (mem_data_out)
  );

  // Memory seen by the DUT (64 words, combinational read).
  logic [31:0] env_mem [0:63];
  assign mem_data_out = env_mem[mem_address[5:0]];
  always @(posedge clk) if (mem_write_enable) env_mem[mem_write_add[5:0]] <= mem_write_data;

  // Model's own view of memory contents.
  logic [31:0] ref_mem [0:63];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules written from the RV32I load/store semantics.
  function automatic logic m_illegal(input logic ld, input logic st, input logic [2:0] f3);
    return (ld == st) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
           (st && (f3 == 3'd4 || f3 == 3'd5));
  endfunction

  function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd1 || f3 == 3'd5) return a % 2 != 0;
    if (f3 == 3'd2)               return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(s[7:0]));
      3'd1:    return 32'($signed(s[15:0]));
      3'd4:    return s & 32'hFF;
      3'd5:    return s & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] mask;
    mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  // Model state: one request in flight, its latency and predicted results.
  logic        m_busy = 1'b0;
  int          m_age, m_lat;
  logic [31:0] m_rdata, m_merged, m_word;
  logic        m_mis, m_ill, m_legal, m_exp_re, m_exp_we;

  // Compare process: predicts every output for the current cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("we_during_rst", 32'(mem_write_enable), 32'd0);
      m_busy = 1'b0;
    end else if (!m_busy) begin
      check("ready_idle", 32'(req_ready), 32'd1);
      check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      if (req_valid) begin
        m_ill    = m_illegal(req_is_load, req_is_store, req_funct3);
        m_mis    = !m_ill && m_misaligned(req_funct3, req_addr);
        m_legal  = !m_ill && !m_mis;
        m_word   = req_addr / 4;
        m_exp_re = m_legal && (req_is_load || req_funct3 != 3'd2);
        m_exp_we = m_legal && req_is_store && req_funct3 == 3'd2;
        check("accept_re", 32'(mem_read_enable), 32'(m_exp_re));
        check("accept_we", 32'(mem_write_enable), 32'(m_exp_we));
        if (m_exp_re || m_exp_we) check("accept_addr", mem_address, m_word);
        if (m_exp_we) begin
          check("sw_data", mem_write_data, req_wdata);
          check("sw_waddr", mem_write_add, m_word);
          ref_mem[m_word[5:0]] = req_wdata;
        end
        m_rdata  = (m_legal && req_is_load) ? m_load(ref_mem[m_word[5:0]], req_funct3, req_addr[1:0]) : 32'd0;
        m_merged = m_store(ref_mem[m_word[5:0]], req_wdata, req_funct3, req_addr[1:0]);
        m_lat    = (m_legal && req_is_store && req_funct3 != 3'd2) ? 2 : 1;
        m_age    = 1;
        m_busy   = 1'b1;
      end else begin
        check("idle_re", 32'(mem_read_enable), 32'd0);
        check("idle_we", 32'(mem_write_enable), 32'd0);
      end
    end else begin
      check("ready_busy", 32'(req_ready), 32'd0);
      check("busy_re", 32'(mem_read_enable), 32'd0);
      if (m_age < m_lat) begin
        check("merge_rsp_valid", 32'(rsp_valid), 32'd0);
        check("merge_we", 32'(mem_write_enable), 32'd1);
        check("merge_waddr", mem_write_add, m_word);
        check("merge_data", mem_write_data, m_merged);
        ref_mem[m_word[5:0]] = m_merged;
        m_age++;
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_misaligned", 32'(rsp_misaligned), 32'(m_mis));
        check("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
        check("resp_we", 32'(mem_write_enable), 32'd0);
        m_busy = 1'b0;
      end
    end
  end

  // Observations of the last request issued through issue().
  logic [31:0] last_rdata, last_wdata;
  logic        last_mis, last_ill, last_en;
  int          last_lat, last_wcount;

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int  n;
    bit  got;
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_load = ld; req_is_store = st;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 20) begin check("accept_timeout", 32'd0, 32'd1); break; end
    end
    last_en     = mem_read_enable | mem_write_enable;
    last_wcount = int'(mem_write_enable);
    if (mem_write_enable) last_wdata = mem_write_data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    last_lat = 0;
    got = 1'b0;
    while (!got && last_lat < 10) begin
      @(negedge clk);
      last_lat++;
      if (mem_write_enable) begin last_wcount++; last_wdata = mem_write_data; end
      if (rsp_valid) begin
        got = 1'b1;
        last_rdata = rsp_rdata; last_mis = rsp_misaligned; last_ill = rsp_illegal;
      end
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int acc, cmp;
    logic [31:0] rv;
    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      rv = $urandom;
      env_mem[i] <= rv;
      ref_mem[i] = rv;
    end
    env_mem[4] <= 32'h8000_00F0; ref_mem[4] = 32'h8000_00F0;
    env_mem[8] <= 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_flags", {30'd0, rsp_misaligned, rsp_illegal}, 32'd0);

    // Sign/zero-extended sub-word loads from 0x8000_00F0.
    issue(1, 0, 3'd0, 32'h10, 32'd0);
    check("lb_10", last_rdata, 32'hFFFF_FFF0);
    check("lb_lat", 32'(last_lat), 32'd1);
    issue(1, 0, 3'd4, 32'h13, 32'd0);
    check("lbu_13", last_rdata, 32'h0000_0080);
    issue(1, 0, 3'd1, 32'h12, 32'd0);
    check("lh_12", last_rdata, 32'hFFFF_8000);

    // SH accepted, then reset lands in its MERGE cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
    req_funct3 = 3'd1; req_addr = 32'h20; req_wdata = 32'h0000_5566;
    @(negedge clk);
    check("abort_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_we", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem", env_mem[8], 32'h1122_3344);
    check("abort_rsp", 32'(rsp_valid), 32'd0);

    // Byte store merge and word store/load round trip.
    issue(0, 1, 3'd0, 32'h21, 32'h0000_00AB);
    check("sb_lat", 32'(last_lat), 32'd2);
    check("sb_writes", 32'(last_wcount), 32'd1);
    check("sb_word", last_wdata, 32'h1122_AB44);
    issue(0, 1, 3'd2, 32'h24, 32'hDEAD_BEEF);
    check("sw_lat", 32'(last_lat), 32'd1);
    check("sw_rdata", last_rdata, 32'd0);
    check("sw_word", last_wdata, 32'hDEAD_BEEF);
    issue(1, 0, 3'd2, 32'h24, 32'd0);
    check("lw_24", last_rdata, 32'hDEAD_BEEF);

    // Error responses make no memory access.
    issue(1, 0, 3'd2, 32'h22, 32'd0);
    check("lw_22_mis", {last_mis, last_ill, last_en}, 32'b100);
    check("lw_22_rdata", last_rdata, 32'd0);
    issue(0, 1, 3'd1, 32'h23, 32'h1234);
    check("sh_23_mis", {last_mis, last_ill, last_en}, 32'b100);
    issue(1, 0, 3'd3, 32'h10, 32'd0);
    check("f3_011_ill", {last_mis, last_ill, last_en}, 32'b010);

    // req_valid held high: one acceptance per completion, period 3 for SB.
    @(posedge clk); #1;
    req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
    req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = $urandom;
    acc = 0; cmp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      if (rsp_valid) cmp++;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    check("held_accepts", 32'(acc), 32'd10);
    check("held_completions", 32'(cmp), 32'd10);

    // Randomized stream; the compare process checks every cycle.
    for (int k = 0; k < 300; k++) begin
      int  cls;
      logic ld, st;
      cls = int'($urandom_range(0, 9));
      ld = (cls == 1) || (cls >= 2 && cls <= 5);
      st = (cls == 1) || (cls >= 6);
      issue(ld, st, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 64; i++) check("final_mem", env_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
